// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life step controller: default grid
// geometry, index widths, FSM state encoding and toroidal index helpers.
package life_pkg;

    localparam int COLS_DEFAULT  = 20;
    localparam int ROWS_DEFAULT  = 15;
    localparam int GEN_W_DEFAULT = 16;

    // Address widths are fixed by the display: x[9:5] and y[8:5].
    localparam int COL_W = 5;
    localparam int ROW_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_SWAP = 2'd3
    } life_state_t;

    // Column to the left, wrapping column 0 to the last column.
    function automatic logic [COL_W-1:0] col_prev(input logic [COL_W-1:0] c, input int cols);
        return (c == '0) ? COL_W'(cols - 1) : c - COL_W'(1);
    endfunction

    // Column to the right, wrapping the last column to column 0.
    function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] c, input int cols);
        return (int'(c) == cols - 1) ? '0 : c + COL_W'(1);
    endfunction

    // Row above, wrapping row 0 to the last row.
    function automatic logic [ROW_W-1:0] row_prev(input logic [ROW_W-1:0] r, input int rows);
        return (r == '0) ? ROW_W'(rows - 1) : r - ROW_W'(1);
    endfunction

    // Row below, wrapping the last row to row 0.
    function automatic logic [ROW_W-1:0] row_next(input logic [ROW_W-1:0] r, input int rows);
        return (int'(r) == rows - 1) ? '0 : r + ROW_W'(1);
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Conway B3/S23 rule for a single cell: counts the eight neighbour bits and
// decides whether the centre cell is alive in the next generation.
module life_cell_rule (
    input  logic [7:0] i_nbr,
    input  logic       i_centre,
    output logic       o_next
);

    logic [3:0] w_count;

    // Population count of the eight neighbours (max 8, fits in 4 bits).
    always_comb begin
        w_count = '0;
        for (int k = 0; k < 8; k++) begin
            w_count = w_count + 4'(i_nbr[k]);
        end
    end

    // Birth on exactly 3, survival on 2 or 3.
    assign o_next = (w_count == 4'd3) | (i_centre & (w_count == 4'd2));

endmodule

// File: rtl/life_step_controller.sv
// Game-of-Life grid owner. Evaluates one cell per clock into a shadow grid
// with toroidal wrap, then commits the whole generation on a frame tick so
// the display read port never sees a half-updated grid.
module life_step_controller
    import life_pkg::*;
#(
    parameter int COLS  = COLS_DEFAULT,
    parameter int ROWS  = ROWS_DEFAULT,
    parameter int GEN_W = GEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [ROW_W-1:0] wr_row,
    input  logic             wr_val,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    output logic             rd_alive,
    output logic             busy,
    output logic [GEN_W-1:0] generation
);

    life_state_t r_state;
    life_state_t w_state_next;

    // Displayed generation and the shadow generation being built.
    logic [ROWS-1:0][COLS-1:0] r_cur;
    logic [ROWS-1:0][COLS-1:0] r_nxt;

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [GEN_W-1:0] r_gen;

    logic w_trigger;
    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_last_col;
    logic w_last_cell;

    logic w_do_clear;
    logic w_do_write;
    logic w_do_start;
    logic w_do_eval;
    logic w_do_swap;

    logic [COL_W-1:0] w_col_l;
    logic [COL_W-1:0] w_col_r;
    logic [ROW_W-1:0] w_row_u;
    logic [ROW_W-1:0] w_row_d;
    logic [7:0]       w_nbr;
    logic             w_centre;
    logic             w_cell_next;

    // ------------------------------------------------------------------
    // Decodes shared by the FSM and the datapath
    // ------------------------------------------------------------------
    assign w_trigger     = step | (run & frame_tick);
    assign w_wr_in_range = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
    assign w_rd_in_range = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);
    assign w_last_col    = (int'(r_col) == COLS - 1);
    assign w_last_cell   = w_last_col && (int'(r_row) == ROWS - 1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a trigger only wins in IDLE when no clear/write competes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!clear && !wr_en && w_trigger) begin
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_last_cell) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (frame_tick) begin
                    w_state_next = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output/control decode from the current state and the IDLE priority chain.
    always_comb begin
        busy       = 1'b1;
        w_do_clear = 1'b0;
        w_do_write = 1'b0;
        w_do_start = 1'b0;
        w_do_eval  = 1'b0;
        w_do_swap  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy       = 1'b0;
                w_do_clear = clear;
                // An out-of-range write still blocks a trigger; it just lands nowhere.
                w_do_write = !clear && wr_en && w_wr_in_range;
                w_do_start = !clear && !wr_en && w_trigger;
            end
            ST_SCAN: w_do_eval = 1'b1;
            ST_SWAP: w_do_swap = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Neighbour gather and rule evaluation for the cell under the scan pointer
    // ------------------------------------------------------------------
    assign w_col_l = col_prev(r_col, COLS);
    assign w_col_r = col_next(r_col, COLS);
    assign w_row_u = row_prev(r_row, ROWS);
    assign w_row_d = row_next(r_row, ROWS);

    assign w_centre = r_cur[r_row][r_col];
    assign w_nbr = {r_cur[w_row_u][w_col_l], r_cur[w_row_u][r_col], r_cur[w_row_u][w_col_r],
                    r_cur[r_row][w_col_l],                          r_cur[r_row][w_col_r],
                    r_cur[w_row_d][w_col_l], r_cur[w_row_d][r_col], r_cur[w_row_d][w_col_r]};

    life_cell_rule u_rule (
        .i_nbr    (w_nbr),
        .i_centre (w_centre),
        .o_next   (w_cell_next)
    );

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Current grid: host clear/seed writes in IDLE, whole-grid commit in SWAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur <= '0;
        end else if (w_do_clear) begin
            r_cur <= '0;
        end else if (w_do_write) begin
            r_cur[wr_row][wr_col] <= wr_val;
        end else if (w_do_swap) begin
            r_cur <= r_nxt;
        end
    end

    // Shadow grid: one evaluated cell written per SCAN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nxt <= '0;
        end else if (w_do_eval) begin
            r_nxt[r_row][r_col] <= w_cell_next;
        end
    end

    // Scan pointer: column innermost, wraps back to (0,0) after the last cell.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_do_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_do_eval) begin
            r_col <= w_col_r;
            if (w_last_col) begin
                r_row <= w_row_d;
            end
        end
    end

    // Generation counter: counts commits, wraps naturally at 2^GEN_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gen <= '0;
        end else if (w_do_swap) begin
            r_gen <= r_gen + GEN_W'(1);
        end
    end

    assign generation = r_gen;
    assign rd_alive   = w_rd_in_range ? r_cur[rd_row][rd_col] : 1'b0;

endmodule

// File: tb/tb_life_step_controller.sv
// Bench for life_step_controller: directed stimulus pushes hand-computed
// expectations into a queue; a monitor process pops and compares them
// against busy/generation and the display read port.
module tb_life_step_controller;

    localparam int NC = 20;
    localparam int NR = 15;
    localparam int NCELLS = NC * NR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       clear = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_col = '0;
    logic [3:0] wr_row = '0;
    logic       wr_val = 1'b0;
    logic [4:0] rd_col = '0;
    logic [3:0] rd_row = '0;
    logic       rd_alive;
    logic       busy;
    logic [15:0] generation;

    int checks = 0;
    int failures = 0;
    int pending = 0;

    typedef enum int {K_BUSY, K_GEN, K_CELL, K_GRID} kind_e;
    typedef struct {
        kind_e              kind;
        string              name;
        int                 col;
        int                 row;
        int                 val;
        logic [NCELLS-1:0]  grid;
    } exp_t;

    exp_t exp_q[$];

    life_step_controller dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .run        (run),
        .step       (step),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_val     (wr_val),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_alive   (rd_alive),
        .busy       (busy),
        .generation (generation)
    );

    always #5 clk = ~clk;

    function automatic int cell_idx(input int c, input int r);
        return r * NC + c;
    endfunction

    // ---------------- scoreboard push helpers ----------------
    task automatic push(input kind_e k, input string n, input int c, input int r,
                        input int v, input logic [NCELLS-1:0] g);
        exp_t e;
        e.kind = k; e.name = n; e.col = c; e.row = r; e.val = v; e.grid = g;
        exp_q.push_back(e);
        pending++;
    endtask

    task automatic exp_busy(input string n, input int v);
        push(K_BUSY, n, 0, 0, v, '0);
    endtask

    task automatic exp_gen(input string n, input int v);
        push(K_GEN, n, 0, 0, v, '0);
    endtask

    task automatic exp_cell(input string n, input int c, input int r, input int v);
        push(K_CELL, n, c, r, v, '0);
    endtask

    task automatic exp_grid(input string n, input logic [NCELLS-1:0] g);
        push(K_GRID, n, 0, 0, 0, g);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        int   bad;
        int   fc, fr, fa;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                case (e.kind)
                    K_BUSY: begin
                        if (int'(busy) != e.val) begin
                            failures++;
                            $display("FAIL %s busy actual=%0d required=%0d", e.name, busy, e.val);
                        end
                    end
                    K_GEN: begin
                        if (int'(generation) != e.val) begin
                            failures++;
                            $display("FAIL %s generation actual=%0d required=%0d", e.name, generation, e.val);
                        end
                    end
                    K_CELL: begin
                        rd_col = 5'(e.col);
                        rd_row = 4'(e.row);
                        #1;
                        if (int'(rd_alive) != e.val) begin
                            failures++;
                            $display("FAIL %s rd_alive(%0d,%0d) actual=%0d required=%0d",
                                     e.name, e.col, e.row, rd_alive, e.val);
                        end
                    end
                    K_GRID: begin
                        bad = 0; fc = 0; fr = 0; fa = 0;
                        for (int r = 0; r < NR; r++) begin
                            for (int c = 0; c < NC; c++) begin
                                rd_col = 5'(c);
                                rd_row = 4'(r);
                                #1;
                                if (rd_alive !== e.grid[cell_idx(c, r)]) begin
                                    if (bad == 0) begin
                                        fc = c; fr = r; fa = int'(rd_alive);
                                    end
                                    bad++;
                                end
                            end
                        end
                        if (bad != 0) begin
                            failures++;
                            $display("FAIL %s grid bad_cells=%0d first=(%0d,%0d) actual=%0d required=%0d",
                                     e.name, bad, fc, fr, fa, int'(e.grid[cell_idx(fc, fr)]));
                        end
                    end
                    default: ;
                endcase
                pending--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the monitor to finish all queued comparisons (bounded).
    task automatic drain();
        int t;
        t = 0;
        while (pending != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (pending != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending actual=%0d required=0", pending);
        end
    endtask

    task automatic wr(input int c, input int r, input int v);
        wr_en  = 1'b1;
        wr_col = 5'(c);
        wr_row = 4'(r);
        wr_val = v[0];
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset(input string n);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_busy({n, "_busy"}, 0);
        exp_gen({n, "_gen"}, 0);
        exp_grid({n, "_grid"}, '0);
        drain();
    endtask

    // ---------------- directed tests ----------------
    initial begin : stimulus
        logic [NCELLS-1:0] g;

        tick(2);
        do_reset("reset0");

        // 1: blinker, exact scan length and late tick in last SCAN cycle
        wr(5, 5, 1); wr(6, 5, 1); wr(7, 5, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        exp_busy("blink_scan_start", 1);
        tick(299);
        exp_busy("blink_scan_last", 1);
        frame_tick = 1'b1;          // lands on the final SCAN edge: must be ignored
        tick();
        frame_tick = 1'b0;
        tick(3);
        exp_busy("blink_hold", 1);
        exp_gen("blink_hold_gen", 0);
        exp_cell("blink_hold_cur55", 5, 5, 1);
        exp_cell("blink_hold_cur64", 6, 4, 0);
        drain();
        pulse_tick();
        exp_busy("blink_swap_busy", 1);
        exp_gen("blink_swap_gen", 0);
        tick();
        g = '0;
        g[cell_idx(6, 4)] = 1'b1; g[cell_idx(6, 5)] = 1'b1; g[cell_idx(6, 6)] = 1'b1;
        exp_busy("blink_idle", 0);
        exp_gen("blink_gen", 1);
        exp_grid("blink_grid", g);
        drain();

        // 2: block still life under free-run, 4 ticks -> 2 generations
        do_reset("reset2");
        wr(0, 0, 1); wr(1, 0, 1); wr(0, 1, 1); wr(1, 1, 1);
        run = 1'b1;
        repeat (4) begin
            pulse_tick();
            tick(399);
        end
        run = 1'b0;
        g = '0;
        g[cell_idx(0, 0)] = 1'b1; g[cell_idx(1, 0)] = 1'b1;
        g[cell_idx(0, 1)] = 1'b1; g[cell_idx(1, 1)] = 1'b1;
        exp_busy("block_idle", 0);
        exp_gen("block_gen", 2);
        exp_grid("block_grid", g);
        drain();

        // 3: blinker straddling the left/right edge
        do_reset("reset3");
        wr(19, 7, 1); wr(0, 7, 1); wr(1, 7, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(310);
        pulse_tick();
        tick(2);
        g = '0;
        g[cell_idx(0, 6)] = 1'b1; g[cell_idx(0, 7)] = 1'b1; g[cell_idx(0, 8)] = 1'b1;
        exp_gen("wrap_gen", 1);
        exp_grid("wrap_grid", g);
        drain();

        // 4: write beats step; host writes/clear ignored while busy
        do_reset("reset4");
        wr_en = 1'b1; wr_col = 5'd3; wr_row = 4'd3; wr_val = 1'b1; step = 1'b1;
        tick();
        wr_en = 1'b0; step = 1'b0;
        exp_busy("prio_busy", 0);
        exp_cell("prio_cell33", 3, 3, 1);
        drain();
        step = 1'b1;
        tick();
        step = 1'b0;
        wr(10, 10, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick(305);
        exp_busy("prio_hold", 1);
        exp_cell("prio_hold33", 3, 3, 1);
        exp_cell("prio_hold1010", 10, 10, 0);
        drain();
        pulse_tick();
        tick(2);
        exp_gen("prio_gen", 1);
        exp_grid("prio_grid", '0);
        drain();

        // 5: reset in the middle of a scan after one committed generation
        do_reset("reset5");
        wr(5, 5, 1); wr(6, 5, 1); wr(7, 5, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(305);
        pulse_tick();
        tick(2);
        exp_gen("midrst_pre_gen", 1);
        drain();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(150);
        exp_busy("midrst_scan", 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_busy("midrst_busy", 0);
        exp_gen("midrst_gen", 0);
        exp_grid("midrst_grid", '0);
        drain();
        tick(5);
        exp_busy("midrst_settled", 0);
        drain();

        // 6: read/write range limits, clearing writes, clear beats step
        do_reset("reset6");
        wr(0, 0, 1); wr(19, 14, 1); wr(20, 3, 1); wr(5, 15, 1);
        g = '0;
        g[cell_idx(0, 0)] = 1'b1; g[cell_idx(19, 14)] = 1'b1;
        exp_cell("rd_col20", 20, 0, 0);
        exp_cell("rd_row15", 0, 15, 0);
        exp_cell("rd_31_15", 31, 15, 0);
        exp_cell("rd_19_14", 19, 14, 1);
        exp_grid("range_grid", g);
        drain();
        wr(19, 14, 0);
        exp_cell("wr_zero", 19, 14, 0);
        exp_cell("wr_keep", 0, 0, 1);
        drain();
        wr(7, 7, 1);
        clear = 1'b1; step = 1'b1;
        tick();
        clear = 1'b0; step = 1'b0;
        exp_busy("clear_busy", 0);
        exp_grid("clear_grid", '0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
